// File: rtl/field_order_scheduler_if.sv
// Decoder-lane and downstream field-stream signals of the field order scheduler.
// The master modport is the decoder-array/downstream side; the slave modport is the scheduler.
interface field_order_scheduler_if #(
    parameter int NUM_DECODERS     = 4,
    parameter int BEAT_WIDTH       = 64,
    parameter int MAX_MESSAGE_SIZE = 10,
    parameter int MSGID_WIDTH      = 21
);
    localparam int IDXW = $clog2(MAX_MESSAGE_SIZE);

    logic [NUM_DECODERS-1:0]             in_valid;
    logic [NUM_DECODERS-1:0]             in_ready;
    logic [NUM_DECODERS-1:0]             in_last;
    logic [NUM_DECODERS*MSGID_WIDTH-1:0] in_msgid;
    logic [NUM_DECODERS*IDXW-1:0]        in_idx;
    logic [NUM_DECODERS*BEAT_WIDTH-1:0]  in_data;

    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic [MSGID_WIDTH-1:0] out_msgid;
    logic [IDXW-1:0]        out_idx;
    logic [BEAT_WIDTH-1:0]  out_data;

    modport master (
        output in_valid, in_last, in_msgid, in_idx, in_data, out_ready,
        input  in_ready, out_valid, out_last, out_msgid, out_idx, out_data
    );

    modport slave (
        input  in_valid, in_last, in_msgid, in_idx, in_data, out_ready,
        output in_ready, out_valid, out_last, out_msgid, out_idx, out_data
    );
endinterface

// File: rtl/field_order_scheduler.sv
// Merges per-lane decoded FAST fields into one in-order stream by draining lanes round-robin.
// Optional macro SEQ_CHECK_EN adds a sticky message-ID sequence checker (seq_err port).
module field_order_scheduler #(
    parameter int NUM_DECODERS     = 4,
    parameter int BEAT_WIDTH       = 64,
    parameter int MAX_MESSAGE_SIZE = 10,
    parameter int MSGID_WIDTH      = 21,
    parameter int LANE_DEPTH       = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    field_order_scheduler_if.slave          bus,
    output logic [$clog2(NUM_DECODERS)-1:0] cur_lane
`ifdef SEQ_CHECK_EN
    ,
    output logic                            seq_err
`endif
);
    localparam int IDXW  = $clog2(MAX_MESSAGE_SIZE);
    localparam int LANEW = $clog2(NUM_DECODERS);
    localparam int PTRW  = $clog2(LANE_DEPTH);
    localparam int CNTW  = PTRW + 1;
    localparam int EW    = 1 + MSGID_WIDTH + IDXW + BEAT_WIDTH;

    logic [NUM_DECODERS-1:0] lane_ready;
    logic [NUM_DECODERS-1:0] lane_nonempty;
    logic [NUM_DECODERS-1:0] pop;
    logic [EW-1:0]           lane_head [NUM_DECODERS];
    logic [EW-1:0]           head;
    logic                    load;

    logic                   out_valid_q;
    logic                   out_last_q;
    logic [MSGID_WIDTH-1:0] out_msgid_q;
    logic [IDXW-1:0]        out_idx_q;
    logic [BEAT_WIDTH-1:0]  out_data_q;

    // Only the current lane is ever popped; an empty current lane stalls the stream.
    assign head = lane_head[cur_lane];
    assign load = lane_nonempty[cur_lane] & (~out_valid_q | bus.out_ready);

    assign bus.in_ready  = lane_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_msgid = out_msgid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;

    for (genvar g = 0; g < NUM_DECODERS; g++) begin : g_lane
        logic [EW-1:0]   mem [LANE_DEPTH];
        logic [PTRW-1:0] wr_ptr;
        logic [PTRW-1:0] rd_ptr;
        logic [CNTW-1:0] count;
        logic            push;

        assign lane_ready[g]    = (count != CNTW'(LANE_DEPTH));
        assign lane_nonempty[g] = (count != '0);
        assign push             = bus.in_valid[g] & lane_ready[g];
        assign pop[g]           = load & (cur_lane == LANEW'(g));
        assign lane_head[g]     = mem[rd_ptr];

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= {bus.in_last[g],
                                bus.in_msgid[g*MSGID_WIDTH +: MSGID_WIDTH],
                                bus.in_idx[g*IDXW +: IDXW],
                                bus.in_data[g*BEAT_WIDTH +: BEAT_WIDTH]};
            end
        end

        // Storage is not cleared; resetting the pointers and count empties the lane.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTRW'(1);
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + PTRW'(1);
                end
                case ({push, pop[g]})
                    2'b10:   count <= count + CNTW'(1);
                    2'b01:   count <= count - CNTW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Output stage: loads from the current lane head and rotates lanes once a last field loads.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_msgid_q <= '0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            cur_lane    <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            {out_last_q, out_msgid_q, out_idx_q, out_data_q} <= head;
            if (head[EW-1]) begin
                cur_lane <= cur_lane + LANEW'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef SEQ_CHECK_EN
    logic [MSGID_WIDTH-1:0] exp_id;
    logic [MSGID_WIDTH-1:0] head_msgid;
    logic [IDXW-1:0]        head_idx;

    assign head_msgid = head[EW-2 -: MSGID_WIDTH];
    assign head_idx   = head[BEAT_WIDTH +: IDXW];

    // Every message start must carry the ID following the previous start; errors are sticky.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            seq_err <= 1'b0;
            exp_id  <= '0;
        end else if (load && head_idx == '0) begin
            if (head_msgid != exp_id) begin
                seq_err <= 1'b1;
            end
            exp_id <= head_msgid + MSGID_WIDTH'(1);
        end
    end
`endif
endmodule
